blackjack_input_conditioner: RTL
================================

Name: blackjack_input_conditioner

Overview:
- Input-side counterpart of the seven-segment/LED output path on the Basys 3 blackjack design.
- Takes raw push-buttons (next, hit, stand, double) and raw slide switches (split, bet_8..bet_1).
- Synchronises and debounces each input, then presents to top:
  - clean switch levels,
  - one-clock-wide press pulses for buttons.
- Sits between board pins and top; top sees exactly one pulse per physical press.

Parameters:
- NUM_BTN, 4, number of push-button inputs (bit0 next, bit1 hit, bit2 stand, bit3 double).
- NUM_SW, 5, number of switch inputs (bit4 split, bit3 bet_8, bit2 bet_4, bit1 bet_2, bit0 bet_1).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50000000, auto-repeat first-repeat delay in cycles (used only with macro).
- REPEAT_PERIOD, 20000000, auto-repeat interval in cycles (used only with macro).
- REPEAT_MASK, 4'b0010, buttons eligible for auto-repeat (used only with macro).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  reset, synchronous, active-high.
- btn_raw  in  NUM_BTN  asynchronous raw button pins.
- sw_raw  in  NUM_SW  asynchronous raw switch pins.
- btn_level  out  NUM_BTN  debounced button level.
- btn_pulse  out  NUM_BTN  one-cycle pulse on accepted press.
- sw_level  out  NUM_SW  debounced switch level.
- sw_changed  out  1  one-cycle pulse when any bit of sw_level changes.

Behaviour:
- Synchroniser:
  - Each raw bit passes through a 2-FF synchroniser (s1, s2).
  - Debounce logic uses s2 only.
- Per-bit debounce:
  - Each bit has a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Any return of s2 to stable before terminal count clears the counter. No partial credit: a bounce restarts the count.
- Latency:
  - Edge E0 is the first edge that samples raw at its new value into s1.
  - The level change appears at edge E0+DEBOUNCE_CYCLES+1.
- btn_pulse:
  - Registered; asserted for exactly one cycle on the same edge btn_level goes 0->1.
  - Never asserted on release or while held (absent macro).
- sw_changed:
  - Registered; asserted for one cycle on any edge where at least one sw_level bit changes.
  - Multiple bits changing together produce a single pulse.
- Independence:
  - All bits are independent.
  - Simultaneous presses produce simultaneous pulses; no priority or masking.
- Reset:
  - While reset is high at a clock edge: s1, s2, stable, counters, btn_level, btn_pulse, sw_level, sw_changed all <= 0.
  - Reset mid-count discards the count.
  - After reset, a still-held button or a high switch is re-accepted through the full debounce and generates a fresh pulse/sw_changed.
- Counters saturate by design (cleared at terminal count); no wrap-around possible.

Optional Feature:
- Macro: BLACKJACK_BTN_AUTO_REPEAT_EN.
- Defined:
  - A button in REPEAT_MASK held with btn_level=1 emits an extra one-cycle btn_pulse REPEAT_DELAY cycles after its press pulse.
  - It then emits a pulse every REPEAT_PERIOD cycles until btn_level falls or reset.
  - Each button has its own repeat counter, cleared on release or reset.
  - Unmasked buttons behave as without the macro.
- Undefined:
  - No repeat counters are synthesised.
  - REPEAT_* parameters are ignored.
  - Exactly one pulse per press.

Test Plan (DEBOUNCE_CYCLES=4):
- Press: reset, then btn_raw=4'b0010 held from edge E0 -> btn_level[1] and btn_pulse[1] rise at E0+5; pulse low at E0+6; level stays 1; other bits 0.
- Bounce: btn_raw[1] high for 3 cycles then low -> btn_level=0 and btn_pulse=0 throughout; a later 10-cycle press yields exactly one pulse.
- Release: after an accepted press, drop btn_raw[1] at E1 -> btn_level[1] falls at E1+5; no btn_pulse.
- Switches: sw_raw=5'b01011 from E0 -> sw_level=5'b01011 and sw_changed=1 at E0+5, sw_changed low at E0+6; bet value seen by top = 11.
- Reset mid-operation: btn_raw=4'b1111 held, reset high at counter=2 -> all outputs 0 at next edge; after reset release, all four pulses fire together 5 edges after release-plus-sync, one cycle each.
- Macro on (REPEAT_DELAY=10, REPEAT_PERIOD=4, REPEAT_MASK=4'b0010): hold hit and stand -> hit pulses at P, P+10, P+14, P+18...; stand pulses only at P.

Source files
------------

// File: rtl/blackjack_input_conditioner.sv
// ---------------------------------------------------------------------------
// blackjack_input_conditioner
//
// Input conditioning for the Basys 3 blackjack board. Every raw push-button
// and slide switch is synchronised (2-FF) and debounced. The board top sees:
// clean levels, one clock-wide press pulses for the buttons, and a single
// sw_changed pulse whenever any debounced switch level changes.
//
// Optional feature: define BLACKJACK_BTN_AUTO_REPEAT_EN to enable button
// auto-repeat. Buttons selected by REPEAT_MASK then emit extra press pulses
// while held: the first comes REPEAT_DELAY cycles after the press pulse and
// later ones follow every REPEAT_PERIOD cycles. With the macro undefined, no
// repeat logic is built and each press gives exactly one pulse.
//
// Ports
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-high reset
//   btn_raw    in   [NUM_BTN] raw button pins (0 next, 1 hit, 2 stand, 3 double)
//   sw_raw     in   [NUM_SW]  raw switch pins (4 split, 3..0 bet_8..bet_1)
//   btn_level  out  [NUM_BTN] debounced button levels
//   btn_pulse  out  [NUM_BTN] one-cycle pulse on each accepted press
//   sw_level   out  [NUM_SW]  debounced switch levels
//   sw_changed out  one-cycle pulse when any sw_level bit changes
// ---------------------------------------------------------------------------
module blackjack_input_conditioner #(
    parameter int                 NUM_BTN         = 4,
    parameter int                 NUM_SW          = 5,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter int                 REPEAT_DELAY    = 50000000,
    parameter int                 REPEAT_PERIOD   = 20000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_SW-1:0]  sw_level,
    output logic               sw_changed
);

    // Buttons and switches share one debounce path.
    // Buttons occupy the low bits and switches occupy the high bits.
    localparam int NB = NUM_BTN + NUM_SW;
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]      s1_q;
    logic [NB-1:0]      s2_q;
    logic [NB-1:0]      stable_q;
    logic [NB-1:0]      accept;       // bit takes its new level on this edge
    logic [NUM_BTN-1:0] rpt_fire;     // auto-repeat pulse request
    logic [NUM_BTN-1:0] btn_pulse_q;
    logic               sw_changed_q;

    // Per-bit debounce counter. The count restarts from zero whenever s2
    // agrees with the stable level, so a bounce cannot build up partial credit.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_db
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = '0;
                if (s2_q[gi] != stable_q[gi] && cnt_q != TERM)
                    cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign accept[gi] = (s2_q[gi] != stable_q[gi]) && (cnt_q == TERM);
        end
    endgenerate

`ifdef BLACKJACK_BTN_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_rpt
            if (REPEAT_MASK[gi]) begin : g_on
                logic [RW-1:0] rcnt_q;
                logic [RW-1:0] rcnt_d;
                logic          first_q;    // first (long) delay has elapsed
                logic          first_d;
                logic [RW-1:0] target;
                logic          held;

                // The counter is zero on the press-pulse edge and counts every
                // cycle after it. When it reaches target it fires and restarts.
                assign target = first_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
                // The button must stay held through this edge, so no repeat
                // pulse can coincide with an accepted release.
                assign held   = stable_q[gi] & ~accept[gi];
                assign rpt_fire[gi] = held && (rcnt_q == target);

                always_comb begin
                    rcnt_d  = '0;
                    first_d = 1'b0;
                    if (stable_q[gi]) begin
                        first_d = first_q;
                        if (rcnt_q == target) begin
                            first_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        rcnt_q  <= '0;
                        first_q <= 1'b0;
                    end else begin
                        rcnt_q  <= rcnt_d;
                        first_q <= first_d;
                    end
                end
            end else begin : g_off
                assign rpt_fire[gi] = 1'b0;
            end
        end
    endgenerate
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            btn_pulse_q  <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            s1_q         <= {sw_raw, btn_raw};
            s2_q         <= s1_q;
            stable_q     <= stable_q ^ accept;
            // An accepted button bit whose incoming value is 1 is a press.
            btn_pulse_q  <= (accept[NUM_BTN-1:0] & s2_q[NUM_BTN-1:0]) | rpt_fire;
            sw_changed_q <= |accept[NB-1:NUM_BTN];
        end
    end

    assign btn_level  = stable_q[NUM_BTN-1:0];
    assign sw_level   = stable_q[NB-1:NUM_BTN];
    assign btn_pulse  = btn_pulse_q;
    assign sw_changed = sw_changed_q;

endmodule
